// File: rtl/cprv_dmem.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cprv_dmem                                                  |
// | Description : Data-memory responder for the cprv64g memory stage.        |
// |               Accepts one load/store request per cycle, performs a       |
// |               read-before-write array access and returns exactly one     |
// |               response beat per request through a 2-entry FIFO.          |
// | Optional    : CPRV_DMEM_WAIT_EN adds an IDLE/WAIT FSM that delays each   |
// |               access by WAIT_CYCLES cycles.                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//
// Ports:
//   clk               in   1           rising-edge clock
//   rst_n             in   1           asynchronous active-low reset
//   valid_dmem_i      in   1           request valid
//   ready_dmem_o      out  1           request ready (registered state only)
//   addr_dmem_i       in   DATA_WIDTH  byte address, word = addr[3 +: log2(DEPTH)]
//   wdata_dmem_i      in   DATA_WIDTH  store data
//   w_en_dmem_i       in   1           1 = store, 0 = load
//   valid_mem_dmem_o  out  1           response valid
//   ready_mem_dmem_i  in   1           response ready
//   rdata_dmem_o      out  DATA_WIDTH  response data (old word contents)
//
// Parameters:
//   DATA_WIDTH   width of address, write data and read data
//   DEPTH        number of words (power of two, >= 2)
//   WAIT_CYCLES  extra latency per request (1..15), CPRV_DMEM_WAIT_EN only

module cprv_dmem #(
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_dmem_i,
  output logic                  ready_dmem_o,
  input  logic [DATA_WIDTH-1:0] addr_dmem_i,
  input  logic [DATA_WIDTH-1:0] wdata_dmem_i,
  input  logic                  w_en_dmem_i,
  output logic                  valid_mem_dmem_o,
  input  logic                  ready_mem_dmem_i,
  output logic [DATA_WIDTH-1:0] rdata_dmem_o
);

  localparam int IDX_W = $clog2(DEPTH);

  // Storage array; deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Response FIFO state.
  logic [DATA_WIDTH-1:0] rsp_buf_q [2];
  logic                  head_q;
  logic                  tail_q;
  logic [1:0]            count_q;
  logic [1:0]            count_d;

  // Handshake and access-port signals.
  logic                  idle;
  logic                  buf_full;
  logic                  req_fire;
  logic                  push;
  logic                  pop;
  logic [IDX_W-1:0]      req_idx;
  logic [IDX_W-1:0]      acc_idx;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_wen;
  logic [DATA_WIDTH-1:0] rd_word;

  // Byte-offset bits and bits above the word index do not select anything.
  logic                  unused_addr;
  assign unused_addr = ^{addr_dmem_i[2:0], addr_dmem_i[DATA_WIDTH-1:3+IDX_W]};

  assign req_idx  = addr_dmem_i[3 +: IDX_W];
  assign buf_full = (count_q == 2'd2);

  // Depends only on registered count/state, so the consumer's ready never
  // reaches the request side combinationally.
  assign ready_dmem_o = ~buf_full & idle;
  assign req_fire     = valid_dmem_i & ready_dmem_o;

  assign valid_mem_dmem_o = (count_q != 2'd0);
  assign rdata_dmem_o     = rsp_buf_q[head_q];
  assign pop              = valid_mem_dmem_o & ready_mem_dmem_i;

`ifdef CPRV_DMEM_WAIT_EN

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [3:0]            wcnt_q;
  logic [3:0]            wcnt_d;
  logic [IDX_W-1:0]      lat_idx_q;
  logic [DATA_WIDTH-1:0] lat_wdata_q;
  logic                  lat_wen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wcnt_q      <= 4'd0;
      lat_idx_q   <= '0;
      lat_wdata_q <= '0;
      lat_wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      // The request is captured on accept; the array is touched only when
      // the wait expires, using these latched copies.
      if (req_fire) begin
        lat_idx_q   <= req_idx;
        lat_wdata_q <= wdata_dmem_i;
        lat_wen_q   <= w_en_dmem_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d = WAIT;
          wcnt_d  = 4'(WAIT_CYCLES);
        end
      end
      WAIT: begin
        // Counter parks at 1 while the FIFO is full; the access happens on
        // the first cycle with room, so no response is ever dropped.
        if (wcnt_q == 4'd1) begin
          if (!buf_full) begin
            push    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idle      = (state_q == IDLE);
  assign acc_idx   = lat_idx_q;
  assign acc_wdata = lat_wdata_q;
  assign acc_wen   = lat_wen_q;

`else

  // Single-cycle build: every accepted request is serviced on its accept edge.
  logic [3:0] unused_wait;
  assign unused_wait = 4'(WAIT_CYCLES);

  assign idle      = 1'b1;
  assign push      = req_fire;
  assign acc_idx   = req_idx;
  assign acc_wdata = wdata_dmem_i;
  assign acc_wen   = w_en_dmem_i;

`endif

  // Read-before-write: the combinational read sees the pre-edge contents,
  // so a store's response carries the word it overwrote.
  assign rd_word = mem_q[acc_idx];

  always_ff @(posedge clk) begin
    if (push && acc_wen) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      count_q      <= 2'd0;
      rsp_buf_q[0] <= '0;
      rsp_buf_q[1] <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        rsp_buf_q[tail_q] <= rd_word;
        tail_q            <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
    end
  end

endmodule

`default_nettype wire
